// File: rtl/sha_uart_pkg.sv
// rtl/sha_uart_pkg.sv - shared types, constants and helpers for the SHA-to-UART sequencer
// Contents: state_t FSM encoding, digest/ASCII constants, nib2ascii().
package sha_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KICK,
    WAIT_DONE,
    SEND,
    FIN
  } state_t;

  localparam int DIGEST_W_DEF = 256;
  localparam int DIGEST_BYTES = DIGEST_W_DEF / 8;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Lowercase hex digit: 0-9 -> 8'h30-39, a-f -> 8'h61-66 (8'h57 + 10 = 8'h61).
  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/sha_uart_sched_if.sv
// rtl/sha_uart_sched_if.sv - SHA core and UART TX handshake bundle
// Signals: sha_start/sha_done/sha_digest (core side), tx_data/tx_valid/tx_ready (UART side).
// Modports: master = sequencer, slave = core + uart_tx.
interface sha_uart_sched_if #(
  parameter int DIGEST_W = 256
);

  logic                sha_start;
  logic                sha_done;
  logic [DIGEST_W-1:0] sha_digest;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                tx_ready;

  modport master (
    output sha_start, tx_data, tx_valid,
    input  sha_done, sha_digest, tx_ready
  );

  modport slave (
    input  sha_start, tx_data, tx_valid,
    output sha_done, sha_digest, tx_ready
  );

endinterface

// File: rtl/sha_digest_ser.sv
// rtl/sha_digest_ser.sv - digest load/shift register presenting one byte (or nibble) at a time
// Ports: clk, rst (async active-low), load, shift, din[DIGEST_W];
//   raw build: cur_byte[8]; SHA_UART_HEX_ASCII_EN build: nib_lo in, cur_nib[4] out.
// MSB_FIRST selects whether the top or bottom byte is presented and which way the register shifts.
module sha_digest_ser #(
  parameter int DIGEST_W  = 256,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                shift,
  input  logic [DIGEST_W-1:0] din,
`ifdef SHA_UART_HEX_ASCII_EN
  input  logic                nib_lo,
  output logic [3:0]          cur_nib
`else
  output logic [7:0]          cur_byte
`endif
);

  logic [DIGEST_W-1:0] sr;
  logic [7:0]          head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= MSB_FIRST ? (sr << 8) : (sr >> 8);
    end
  end

  assign head = MSB_FIRST ? sr[DIGEST_W-1 -: 8] : sr[7:0];

`ifdef SHA_UART_HEX_ASCII_EN
  // High nibble of each byte goes out first regardless of byte order.
  assign cur_nib = nib_lo ? head[3:0] : head[7:4];
`else
  assign cur_byte = head;
`endif

endmodule

// File: rtl/sha_uart_sched.sv
// rtl/sha_uart_sched.sv - sequencer: kick SHA core, latch digest, stream it to uart_tx, pulse done
// Ports: clk, rst (async active-low), start, bus (sha_uart_sched_if.master), busy, done, err.
// Build option: SHA_UART_HEX_ASCII_EN sends lowercase hex text + CR LF instead of raw bytes.
module sha_uart_sched
  import sha_uart_pkg::*;
#(
  parameter int DIGEST_W    = DIGEST_W_DEF,
  parameter int TIMEOUT_CYC = 4096,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  sha_uart_sched_if.master      bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

`ifdef SHA_UART_HEX_ASCII_EN
  localparam int N_CHARS = DIGEST_W / 4;
  localparam int N_BYTES = N_CHARS + 2;
`else
  localparam int N_BYTES = DIGEST_W / 8;
`endif
  localparam int CNT_W = $clog2(N_BYTES);
  // One spare value so the increment on the final WAIT_DONE cycle cannot overflow.
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] byte_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             xfer, last_xfer, timeout, load, shift;
  logic [7:0]       cur_sym;

  // tx_valid is exactly (state == SEND), so this is the valid&&ready transfer.
  assign xfer      = (state == SEND) && bus.tx_ready;
  assign last_xfer = xfer && (byte_cnt == LAST_IDX);
  assign timeout   = (to_cnt == TO_LAST);
  assign load      = (state == WAIT_DONE) && bus.sha_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // All outputs decode from state only, so reset drops them without a clock edge.
  always_comb begin
    state_nx      = state;
    bus.sha_start = 1'b0;
    bus.tx_valid  = 1'b0;
    bus.tx_data   = 8'h00;
    busy          = 1'b1;
    done          = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = KICK;
      end
      KICK: begin
        bus.sha_start = 1'b1;
        state_nx      = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.sha_done)  state_nx = SEND;
        else if (timeout)  state_nx = IDLE;
      end
      SEND: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = cur_sym;
        if (last_xfer) state_nx = FIN;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt <= '0;
      to_cnt   <= '0;
      err      <= 1'b0;
    end else begin
      if ((state == IDLE) && start) err <= 1'b0;
      if ((state == WAIT_DONE) && !bus.sha_done && timeout) err <= 1'b1;

      if (state == WAIT_DONE) to_cnt <= to_cnt + 1'b1;
      else                    to_cnt <= '0;

      if (load)                         byte_cnt <= '0;
      else if (xfer && !last_xfer)      byte_cnt <= byte_cnt + 1'b1;
    end
  end

`ifdef SHA_UART_HEX_ASCII_EN
  logic [3:0] cur_nib;

  // Advance to the next digest byte only after its low-nibble character is taken.
  assign shift = xfer && byte_cnt[0] && (byte_cnt < CNT_W'(N_CHARS));

  sha_digest_ser #(
    .DIGEST_W  (DIGEST_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_ser (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .shift   (shift),
    .din     (bus.sha_digest),
    .nib_lo  (byte_cnt[0]),
    .cur_nib (cur_nib)
  );

  always_comb begin
    if (byte_cnt < CNT_W'(N_CHARS))       cur_sym = nib2ascii(cur_nib);
    else if (byte_cnt == CNT_W'(N_CHARS)) cur_sym = ASCII_CR;
    else                                  cur_sym = ASCII_LF;
  end
`else
  assign shift = xfer;

  sha_digest_ser #(
    .DIGEST_W  (DIGEST_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift    (shift),
    .din      (bus.sha_digest),
    .cur_byte (cur_sym)
  );
`endif

endmodule

// File: tb/tb_sha_uart_sched.sv
// tb/tb_sha_uart_sched.sv - directed self-checking bench for sha_uart_sched (raw or hex build)
module tb_sha_uart_sched;

`ifdef SHA_UART_HEX_ASCII_EN
  localparam int NB = 66;
  localparam logic [7:0] FIRST_SYM = 8'h62;
  localparam logic [7:0] LAST_SYM  = 8'h0A;
`else
  localparam int NB = 32;
  localparam logic [7:0] FIRST_SYM = 8'hba;
  localparam logic [7:0] LAST_SYM  = 8'had;
`endif

  logic clk, rst, start, busy, done, err;
  logic [255:0] dig;
  logic [7:0]   got[$];
  logic [7:0]   exp_q[$];
  int checks, errors;
  int n_done, n_kick, unstable;
  logic stall_prev;
  logic [7:0] pd;

  sha_uart_sched_if #(.DIGEST_W(256)) bus ();

  sha_uart_sched #(
    .DIGEST_W    (256),
    .TIMEOUT_CYC (16),
    .MSB_FIRST   (1'b1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (bus.master),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive observer on the falling edge: transfers, pulses, stall stability.
  initial begin
    n_done = 0; n_kick = 0; unstable = 0; stall_prev = 1'b0; pd = 8'h00;
  end
  always @(negedge clk) begin
    if (stall_prev && (!bus.tx_valid || bus.tx_data != pd)) unstable++;
    stall_prev = rst && bus.tx_valid && !bus.tx_ready;
    pd = bus.tx_data;
    if (bus.tx_valid && bus.tx_ready) got.push_back(bus.tx_data);
    if (done) n_done++;
    if (bus.sha_start) n_kick++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h61 + {4'h0, n} - 8'd10);
  endfunction

  task automatic build_exp();
    logic [7:0] b;
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      b = dig[255 - 8*i -: 8];
`ifdef SHA_UART_HEX_ASCII_EN
      exp_q.push_back(hexc(b[7:4]));
      exp_q.push_back(hexc(b[3:0]));
`else
      exp_q.push_back(b);
`endif
    end
`ifdef SHA_UART_HEX_ASCII_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic chk_frame(input string tag);
    int mism;
    mism = 0;
    chk({tag, "_len"}, got.size(), NB);
    if (got.size() == NB) begin
      for (int i = 0; i < NB; i++) if (got[i] !== exp_q[i]) mism++;
      chk({tag, "_first"}, got[0], FIRST_SYM);
      chk({tag, "_last"}, got[NB-1], LAST_SYM);
    end
    chk({tag, "_mismatches"}, mism, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // From KICK: two WAIT_DONE cycles, then sha_done with the digest; digest is scrambled afterwards.
  task automatic do_load();
    tick();
    tick();
    bus.sha_digest = dig;
    bus.sha_done   = 1'b1;
    tick();
    bus.sha_done   = 1'b0;
    bus.sha_digest = ~dig;
  endtask

  // Runs SEND until done is seen; returns cycles from SEND entry to the done cycle.
  task automatic run_send(input bit toggle, input int poke_at, output int cyc);
    cyc = 0;
    while (!done && cyc < 2000) begin
      if (toggle) bus.tx_ready = ((cyc / 3) % 2) == 0;
      start = (cyc == poke_at);
      tick();
      cyc++;
    end
    start = 1'b0;
    bus.tx_ready = 1'b1;
    chk("done_seen", done, 1'b1);
  endtask

  initial begin
    int cyc;
    checks = 0; errors = 0;
    dig = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    build_exp();
    rst = 1'b0; start = 1'b0;
    bus.sha_done = 1'b0; bus.sha_digest = '0; bus.tx_ready = 1'b1;
    tick();
    chk("rst_outputs", {bus.sha_start, bus.tx_valid, busy, done, err}, 5'b0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    rst = 1'b1;
    tick();

    // Scenario 1/2: steady tx_ready
    got.delete(); n_done = 0; n_kick = 0;
    do_start();
    chk("s1_sha_start", bus.sha_start, 1'b1);
    chk("s1_busy", busy, 1'b1);
    do_load();
    chk("s1_first_valid", bus.tx_valid, 1'b1);
    chk("s1_first_data", bus.tx_data, FIRST_SYM);
    run_send(1'b0, -1, cyc);
    chk("s1_done_latency", cyc, NB);
    tick();
    chk("s1_done_width", done, 1'b0);
    chk("s1_idle", busy, 1'b0);
    chk_frame("s1");
    chk("s1_n_done", n_done, 1);
    chk("s1_n_kick", n_kick, 1);

    // Scenario 3: tx_ready 1/0 every 3 cycles
    got.delete(); unstable = 0;
    do_start();
    do_load();
    run_send(1'b1, -1, cyc);
    tick();
    chk_frame("s3");
    chk("s3_stable", unstable, 0);

    // Scenario 4: timeout after 16 WAIT_DONE cycles
    got.delete(); n_done = 0;
    do_start();
    tick();
    repeat (15) tick();
    chk("s4_busy_before", busy, 1'b1);
    chk("s4_err_before", err, 1'b0);
    tick();
    chk("s4_err", err, 1'b1);
    chk("s4_busy", busy, 1'b0);
    repeat (3) tick();
    chk("s4_no_bytes", got.size(), 0);
    chk("s4_no_done", n_done, 0);
    chk("s4_err_sticky", err, 1'b1);
    do_start();
    chk("s4_err_cleared", err, 1'b0);
    do_load();
    run_send(1'b0, -1, cyc);
    tick();

    // Scenario 5: async reset after 5 bytes, then a clean frame
    got.delete(); n_done = 0;
    do_start();
    do_load();
    repeat (5) tick();
    rst = 1'b0;
    #1;
    chk("s5_rst_outputs", {bus.sha_start, bus.tx_valid, busy, done, err}, 5'b0);
    chk("s5_rst_tx_data", bus.tx_data, 8'h00);
    tick();
    chk("s5_bytes_before_rst", got.size(), 5);
    chk("s5_no_done", n_done, 0);
    rst = 1'b1;
    tick();
    got.delete();
    do_start();
    do_load();
    run_send(1'b0, -1, cyc);
    tick();
    chk_frame("s5");

    // Scenario 6: start poked in SEND and in the FIN cycle
    got.delete(); n_done = 0; n_kick = 0;
    do_start();
    do_load();
    run_send(1'b0, 3, cyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("s6_fin_start_ignored", busy, 1'b0);
    chk("s6_no_kick", bus.sha_start, 1'b0);
    repeat (3) tick();
    chk("s6_n_kick", n_kick, 1);
    chk("s6_n_done", n_done, 1);
    chk_frame("s6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
